lsu: RTL and testbench
======================

# lsu

Load/store unit between the single-cycle `core` and data memory. It turns one RV32I load or store request into a word-aligned memory transaction with byte enables, and returns sign- or zero-extended load data. It rejects misaligned or illegal accesses without touching memory, and bounds every memory transaction with a timeout. The core holds its PC while `req_ready` is low or a response is outstanding.

## Interface
- `XLEN`, 32: data/address width; only 32 supported.
- `TIMEOUT`, 16: maximum cycles in BUSY waiting for `mem_ack`; ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low; clock clk.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  LSU accepts a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 of the load/store.
- `req_addr`  in  XLEN  byte address (rs1 + imm).
- `req_wdata`  in  XLEN  store data (rs2), low bits significant.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, illegal funct3, bus error or timeout.
- `mem_req`  out  1  memory request, held until ack or timeout.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  XLEN  `{req_addr[31:2], 2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_ack`  in  1  memory completes the transaction this cycle.
- `mem_rdata`  in  XLEN  read word, valid with `mem_ack`.
- `mem_err`  in  1  bus error, qualified by `mem_ack`.

## Operation
- FSM states: IDLE, BUSY, RESP. `req_ready` = (state == IDLE).
- IDLE: on `req_valid`, latch we/funct3/addr/wdata. If the access is legal → BUSY; if it is illegal or misaligned → RESP with err=1, and `mem_req` never rises.
- Legal load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3 values: 000 SB, 001 SH, 010 SW. Every other value is illegal.
- Misaligned: a halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0.
- Byte enables: byte access → `4'b0001 << addr[1:0]`; halfword → `4'b0011 << addr[1:0]`; word → `4'b1111`. `mem_be` is driven for loads as well.
- Store data: byte → `{4{wdata[7:0]}}`; half → `{2{wdata[15:0]}}`; word → `wdata`.
- Load extract: `mem_rdata >> (8*addr[1:0])`. Then sign-extend from bit 7 (LB) or bit 15 (LH), or zero-extend (LBU/LHU). LW passes through.
- BUSY: hold `mem_req`=1 and all mem_* outputs stable.
  - `mem_ack` → RESP, registering the extracted data and `resp_err=mem_err`.
  - Timeout counter reaches TIMEOUT-1 without ack → RESP with err=1. The memory must ignore a request that is dropped without an ack.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- When `resp_err`=1, `resp_rdata`=0. Stores always return `resp_rdata`=0.
- `mem_err` is ignored unless `mem_ack`=1. `mem_ack` is ignored outside BUSY.

## Timing
- Reset (`reset`=0 at a clk edge): state IDLE, counter 0. All outputs are 0 except `req_ready`=1.
- Reset mid-transaction aborts it: `mem_req` is low after the edge and no response is issued.
- Zero-wait memory: accept at cycle 0, `mem_req` high in cycle 1, ack in cycle 1, `resp_valid` in cycle 2. A request is next accepted in cycle 3.
- Illegal or misaligned access: accept at cycle 0, `resp_valid`+`resp_err` in cycle 1, `mem_req` stays 0.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles; `resp_valid` follows in the next cycle.
- `mem_ack` in the same cycle as the final timeout count wins: it is treated as a normal completion.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- `lsu_pkg` holds:
  - `lsu_state_t` enum {IDLE, BUSY, RESP};
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - functions `lsu_be(funct3, addr)` and `lsu_misaligned(funct3, addr)`.
- Sub-module `lsu_load_extract`: combinational lane shift plus sign/zero extension. Inputs are `mem_rdata`, `addr[1:0]` and `funct3`; output is the XLEN result.

## Test plan
- LB at 0x1003, memory returns 0x80FF_0000 with zero wait → `mem_addr`=0x1000, `mem_be`=1000, `resp_rdata`=0xFFFF_FF80, `resp_valid` in cycle 2.
- SH at 0x2002 with wdata 0x1234_ABCD → `mem_be`=1100, `mem_wdata`=0xABCD_ABCD, `mem_we`=1, `resp_rdata`=0.
- LW at 0x3001 → `resp_err`=1 in cycle 1, `mem_req` never asserted. funct3=011 gives the same result.
- LHU at 0x4002 with ack delayed 5 cycles and rdata 0xBEEF_0000 → `mem_req` high for 5 cycles, then `resp_rdata`=0x0000_BEEF.
- Load with no ack and TIMEOUT=16 → `mem_req` high for 16 cycles, `resp_err`=1, then IDLE and a new request is accepted.
- Reset pulled low during BUSY → next cycle `mem_req`=0, `resp_valid`=0, `req_ready`=1 once reset is released.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state type, funct3 encodings and access decode helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic [3:0] lsu_be(input logic [2:0] funct3, input logic [1:0] addr);
    return (funct3 == F3_B || funct3 == F3_BU) ? 4'b0001 << addr :
           (funct3 == F3_H || funct3 == F3_HU) ? 4'b0011 << addr : 4'b1111;
  endfunction
  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    return ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) || (funct3 == F3_W && addr != 2'b00);
  endfunction
  function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3);
    return we ? !(funct3 inside {F3_B, F3_H, F3_W}) : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request/response and data memory bus bundled for the load/store unit
interface lsu_if #(parameter int XLEN = 32);
  logic req_valid, req_ready, req_we;
  logic [2:0] req_funct3;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic resp_valid, resp_err;
  logic [XLEN-1:0] resp_rdata;
  logic mem_req, mem_we, mem_ack, mem_err;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  modport slave(
    input req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata, mem_err,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport master(
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata, mem_err,
    input req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_load_extract.sv
// lsu_load_extract: shifts the addressed lane down and sign/zero-extends it to the load width
module lsu_load_extract import lsu_pkg::*; #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] sh;
  logic sx;
  assign sh = mem_rdata >> {addr, 3'b000};
  assign sx = !funct3[2];
  assign rdata = (funct3 == F3_B || funct3 == F3_BU) ? {{(XLEN-8){sx & sh[7]}}, sh[7:0]} :
                 (funct3 == F3_H || funct3 == F3_HU) ? {{(XLEN-16){sx & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/lsu.sv
// lsu: turns one RV32I load/store into a bounded, word-aligned memory transaction
module lsu import lsu_pkg::*; #(parameter int XLEN = 32, parameter int TIMEOUT = 16) (
  input logic clk,
  input logic reset,
  lsu_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  lsu_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic we_q, err_q, accept, bad, done;
  logic [2:0] f3_q;
  logic [3:0] be_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q, ext;
  assign accept = state == IDLE && bus.req_valid;
  assign bad = lsu_illegal(bus.req_we, bus.req_funct3) || lsu_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign done = state == BUSY && (bus.mem_ack || cnt == LAST);
  lsu_load_extract #(.XLEN(XLEN)) u_ext (
    .mem_rdata(bus.mem_rdata),
    .addr(addr_q[1:0]),
    .funct3(f3_q),
    .rdata(ext)
  );
  // Next state: rejected accesses skip memory; an ack on the last count still completes normally
  always_comb begin
    state_n = state;
    if (accept) state_n = bad ? RESP : BUSY;
    else if (done) state_n = RESP;
    else if (state == RESP) state_n = IDLE;
  end
  // State, timeout counter and the request/response registers that drive every output
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == BUSY ? cnt + 1'b1 : '0;
      if (accept) begin
        we_q <= bus.req_we;
        f3_q <= bus.req_funct3;
        addr_q <= bus.req_addr;
        be_q <= lsu_be(bus.req_funct3, bus.req_addr[1:0]);
        wdata_q <= bus.req_funct3 == F3_B ? {4{bus.req_wdata[7:0]}} :
                   bus.req_funct3 == F3_H ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
        rdata_q <= '0;
        err_q <= bad;
      end
      if (done) begin
        err_q <= !bus.mem_ack || bus.mem_err;
        rdata_q <= (bus.mem_ack && !bus.mem_err && !we_q) ? ext : '0;
      end
    end
  end
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err = err_q;
  assign bus.mem_req = state == BUSY;
  assign bus.mem_we = we_q;
  assign bus.mem_addr = {addr_q[XLEN-1:2], 2'b00};
  assign bus.mem_be = be_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vector table plus reset/idle-ack sequences for the load/store unit
module tb_lsu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  lsu_if #(.XLEN(32)) bus();
  lsu #(.XLEN(32), .TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string name;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wdata, mrd;
    logic merr;
    int ack_at;
    int exp_n;
    logic [3:0] exp_be;
    logic [31:0] exp_wdata, exp_rdata;
    logic exp_err;
  } vec_t;
  vec_t vecs[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int n;
    @(negedge clk);
    check({v.name, " ready"}, 32'(bus.req_ready), 1);
    check({v.name, " idle_memreq"}, 32'(bus.mem_req), 0);
    bus.req_valid = 1'b1;
    bus.req_we = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.mem_req === 1'b1 && n < 40) begin
      n++;
      if (n == 1) begin
        check({v.name, " mem_addr"}, bus.mem_addr, {v.addr[31:2], 2'b00});
        check({v.name, " mem_be"}, 32'(bus.mem_be), 32'(v.exp_be));
        check({v.name, " mem_we"}, 32'(bus.mem_we), 32'(v.we));
        check({v.name, " mem_wdata"}, bus.mem_wdata, v.exp_wdata);
      end
      bus.mem_ack = (n == v.ack_at);
      bus.mem_rdata = v.mrd;
      bus.mem_err = v.merr;
      @(negedge clk);
      bus.mem_ack = 1'b0;
    end
    bus.mem_err = 1'b0;
    check({v.name, " memreq_cycles"}, 32'(n), 32'(v.exp_n));
    check({v.name, " resp_valid"}, 32'(bus.resp_valid), 1);
    check({v.name, " resp_err"}, 32'(bus.resp_err), 32'(v.exp_err));
    check({v.name, " resp_rdata"}, bus.resp_rdata, v.exp_rdata);
    @(negedge clk);
    check({v.name, " resp_pulse"}, 32'(bus.resp_valid), 0);
  endtask
  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0; bus.mem_err = 0;
    //          name       we f3      addr          wdata         mrd           merr ack n  be       wdata         rdata         err
    vecs.push_back('{"lb",    0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 1,  1,  4'b1000, 32'h0,         32'hFFFF_FF80, 0});
    vecs.push_back('{"sh",    1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 1,  1,  4'b1100, 32'hABCD_ABCD, 32'h0,         0});
    vecs.push_back('{"lw_mis",0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,         0, 1,  0,  4'b0000, 32'h0,         32'h0,         1});
    vecs.push_back('{"f3_011",0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,         0, 1,  0,  4'b0000, 32'h0,         32'h0,         1});
    vecs.push_back('{"lhu_w5",0, 3'b101, 32'h0000_4002, 32'h0,        32'hBEEF_0000, 0, 5,  5,  4'b1100, 32'h0,         32'h0000_BEEF, 0});
    vecs.push_back('{"tmo",   0, 3'b010, 32'h0000_5000, 32'h0,        32'h1111_1111, 0, 0,  16, 4'b1111, 32'h0,         32'h0,         1});
    vecs.push_back('{"sw",    1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 32'h0,         0, 2,  2,  4'b1111, 32'hCAFE_F00D, 32'h0,         0});
    vecs.push_back('{"sb",    1, 3'b000, 32'h0000_7001, 32'h0000_00A5, 32'h0,         0, 1,  1,  4'b0010, 32'hA5A5_A5A5, 32'h0,         0});
    vecs.push_back('{"lh",    0, 3'b001, 32'h0000_8002, 32'h0,        32'h8001_1234, 0, 1,  1,  4'b1100, 32'h0,         32'hFFFF_8001, 0});
    vecs.push_back('{"lbu",   0, 3'b100, 32'h0000_9001, 32'h0,        32'h0000_F000, 0, 1,  1,  4'b0010, 32'h0,         32'h0000_00F0, 0});
    vecs.push_back('{"buserr",0, 3'b010, 32'h0000_A000, 32'h0,        32'h5555_5555, 1, 3,  3,  4'b1111, 32'h0,         32'h0,         1});
    vecs.push_back('{"ack_last",0,3'b010, 32'h0000_A004, 32'h0,        32'h1234_5678, 0, 16, 16, 4'b1111, 32'h0,         32'h1234_5678, 0});
    vecs.push_back('{"sh_mis",1, 3'b001, 32'h0000_B001, 32'h0,        32'h0,         0, 1,  0,  4'b0000, 32'h0,         32'h0,         1});
    vecs.push_back('{"st_100",1, 3'b100, 32'h0000_B000, 32'h0,        32'h0,         0, 1,  0,  4'b0000, 32'h0,         32'h0,         1});
    vecs.push_back('{"lh_mis",0, 3'b001, 32'h0000_8001, 32'h0,        32'h0,         0, 1,  0,  4'b0000, 32'h0,         32'h0,         1});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", 32'(bus.req_ready), 1);
    check("rst resp_valid", 32'(bus.resp_valid), 0);
    check("rst mem_req", 32'(bus.mem_req), 0);
    check("rst mem_be", 32'(bus.mem_be), 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst resp_rdata", bus.resp_rdata, 0);
    reset = 1'b1;
    foreach (vecs[i]) run(vecs[i]);
    @(negedge clk);
    bus.mem_ack = 1'b1;
    bus.mem_err = 1'b1;
    @(negedge clk);
    check("idle_ack ready", 32'(bus.req_ready), 1);
    check("idle_ack resp_valid", 32'(bus.resp_valid), 0);
    bus.mem_ack = 1'b0;
    bus.mem_err = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h100;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rstbusy memreq_before", 32'(bus.mem_req), 1);
    reset = 1'b0;
    @(negedge clk);
    check("rstbusy mem_req", 32'(bus.mem_req), 0);
    check("rstbusy resp_valid", 32'(bus.resp_valid), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rstbusy ready", 32'(bus.req_ready), 1);
    check("rstbusy no_resp", 32'(bus.resp_valid), 0);
    run(vecs[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
